// File: rtl/data_sram_resp.sv
// Purpose : data SRAM responder; 64-bit words with byte-lane writes, zero-fill after reset, out-of-range flagging.
// Latency : read data and rvalid appear RD_LAT cycles after the accepting edge; writes land on the accepting edge.
// Backpressure: none; requests are dropped silently while sram_ready is low, and the consumer is always ready.
//
// Ports:
//   clk, reset                     rising-edge clock, asynchronous active-high reset
//   data_sram_en/wen/addr/wdata    request strobe, byte write enables (0 = read), byte address, store data
//   data_sram_rdata/rvalid         read data, qualified by a one-cycle rvalid pulse (rdata holds otherwise)
//   sram_ready                     high once the zero-fill has completed
//   sram_addr_err                  one-cycle pulse, aligned with the rvalid slot, for out-of-range requests
module data_sram_resp #(
    parameter int          ADDR_W    = 10,
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [7:0]  data_sram_wen,
    input  logic [63:0] data_sram_addr,
    input  logic [63:0] data_sram_wdata,
    output logic [63:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        sram_ready,
    output logic        sram_addr_err
);

    localparam int          DEPTH = 1 << ADDR_W;
    localparam logic [63:0] SPAN  = 64'(DEPTH) << 3;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] init_cnt;
    logic              ready_q;

    logic [63:0] mem [DEPTH];

    logic [63:0]       off;
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic              accept;
    logic              acc_rd;
    logic              acc_wr;

    // Read pipeline; stage RD_LAT-1 drives the outputs.
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_err;
    logic [63:0]       pipe_dat [RD_LAT];

    assign off = data_sram_addr - BASE_ADDR;
    // The lower bound is compared on the raw address so a wrapped subtraction
    // can never alias a below-base address into the array.
    assign in_range = (data_sram_addr >= BASE_ADDR) && (off < SPAN);
    assign idx      = off[ADDR_W+2:3];
    assign accept   = data_sram_en & ready_q;
    assign acc_rd   = accept && (data_sram_wen == 8'h00);
    assign acc_wr   = accept && (data_sram_wen != 8'h00);

    // Zero-fill FSM: one entry per cycle; ready rises on the edge that writes
    // the last entry, so it stays low for exactly DEPTH cycles after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            ready_q  <= 1'b0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + ADDR_W'(1);
            if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                state   <= ST_IDLE;
                ready_q <= 1'b1;
            end
        end
    end

    // Array write port, shared by the zero-fill and accepted stores.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= 64'h0;
        end else if (acc_wr && in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (data_sram_wen[b]) begin
                    mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Data registers only load when a valid read passes through, which makes
    // the output stage hold its last value between rvalid pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            pipe_err <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_dat[i] <= 64'h0;
            end
        end else begin
            pipe_vld[0] <= acc_rd;
            pipe_err[0] <= accept && !in_range;
            if (acc_rd) begin
                pipe_dat[0] <= in_range ? mem[idx] : 64'h0;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_err[i] <= pipe_err[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
        end
    end

    assign data_sram_rdata  = pipe_dat[RD_LAT-1];
    assign data_sram_rvalid = pipe_vld[RD_LAT-1];
    assign sram_addr_err    = pipe_err[RD_LAT-1];
    assign sram_ready       = ready_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Purpose : directed bench for data_sram_resp using three instances:
//           dut0 BASE 0 / RD_LAT 1, dut1 BASE 0x1000 / RD_LAT 3, dut2 BASE 0 / RD_LAT 2 (all ADDR_W 4).
// Inputs are driven and outputs sampled at the falling clock edge.
module tb_data_sram_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  en;
    logic [7:0]  wen   [3];
    logic [63:0] addr  [3];
    logic [63:0] wdata [3];
    logic [63:0] rdata [3];
    logic [2:0]  rvalid;
    logic [2:0]  ready;
    logic [2:0]  err;

    int vectors     = 0;
    int miscompares = 0;

    data_sram_resp #(.ADDR_W(4), .BASE_ADDR(64'h0), .RD_LAT(1)) u_dut0 (
        .clk(clk), .reset(rst[0]), .data_sram_en(en[0]), .data_sram_wen(wen[0]),
        .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]), .data_sram_rdata(rdata[0]),
        .data_sram_rvalid(rvalid[0]), .sram_ready(ready[0]), .sram_addr_err(err[0]));

    data_sram_resp #(.ADDR_W(4), .BASE_ADDR(64'h1000), .RD_LAT(3)) u_dut1 (
        .clk(clk), .reset(rst[1]), .data_sram_en(en[1]), .data_sram_wen(wen[1]),
        .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]), .data_sram_rdata(rdata[1]),
        .data_sram_rvalid(rvalid[1]), .sram_ready(ready[1]), .sram_addr_err(err[1]));

    data_sram_resp #(.ADDR_W(4), .BASE_ADDR(64'h0), .RD_LAT(2)) u_dut2 (
        .clk(clk), .reset(rst[2]), .data_sram_en(en[2]), .data_sram_wen(wen[2]),
        .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]), .data_sram_rdata(rdata[2]),
        .data_sram_rvalid(rvalid[2]), .sram_ready(ready[2]), .sram_addr_err(err[2]));

    task automatic idle(input int d);
        en[d]    = 1'b0;
        wen[d]   = 8'h00;
        addr[d]  = 64'h0;
        wdata[d] = 64'h0;
    endtask

    task automatic drive(input int d, input logic [63:0] a, input logic [7:0] w, input logic [63:0] dat);
        en[d]    = 1'b1;
        wen[d]   = w;
        addr[d]  = a;
        wdata[d] = dat;
    endtask

    task automatic test_reset();
        int rdy_at [3];
        int spurious;
        for (int d = 0; d < 3; d++) idle(d);
        rst = 3'b000;
        #1;
        rst = 3'b111;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (rdata[d] !== 64'h0 || rvalid[d] !== 1'b0 || ready[d] !== 1'b0 || err[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: rdata=%h rvalid=%b ready=%b err=%b, required all zero",
                         d, rdata[d], rvalid[d], ready[d], err[d]);
            end
        end
        rst = 3'b000;
        for (int d = 0; d < 3; d++) rdy_at[d] = -1;
        spurious = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rdy_at[d] < 0 && ready[d] === 1'b1) rdy_at[d] = k;
            end
            if (k <= 16 && (rvalid[0] !== 1'b0 || err[0] !== 1'b0)) spurious++;
            // Stores issued while not ready must be ignored (entry 0 is already zeroed).
            if (k == 1)  drive(0, 64'h0, 8'hff, 64'hFFFF_FFFF_FFFF_FFFF);
            if (k == 14) idle(0);
        end
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (rdy_at[d] != 16) begin
                miscompares++;
                $display("FAIL init_length dut%0d: ready after %0d cycles, required 16", d, rdy_at[d]);
            end
        end
        vectors++;
        if (spurious != 0) begin
            miscompares++;
            $display("FAIL ignore_not_ready: %0d cycles with rvalid/err, required 0", spurious);
        end
    endtask

    task automatic test_init_read();
        for (int i = 0; i < 16; i++) begin
            drive(0, 64'(i * 8), 8'h00, 64'h0);
            @(negedge clk);
            vectors++;
            if (rvalid[0] !== 1'b1 || rdata[0] !== 64'h0) begin
                miscompares++;
                $display("FAIL init_read entry%0d: rvalid=%b rdata=%h, required 1 / 0", i, rvalid[0], rdata[0]);
            end
        end
        idle(0);
        @(negedge clk);
    endtask

    task automatic test_full_write_read();
        drive(0, 64'h18, 8'hff, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        vectors++;
        if (rvalid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL write_no_rvalid: rvalid=%b, required 0", rvalid[0]);
        end
        drive(0, 64'h18, 8'h00, 64'h0);
        @(negedge clk);
        vectors++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 64'h0123_4567_89AB_CDEF) begin
            miscompares++;
            $display("FAIL full_write_read: rvalid=%b rdata=%h, required 1 / 0123456789abcdef", rvalid[0], rdata[0]);
        end
        idle(0);
        @(negedge clk);
        vectors++;
        if (rvalid[0] !== 1'b0 || rdata[0] !== 64'h0123_4567_89AB_CDEF) begin
            miscompares++;
            $display("FAIL rdata_hold: rvalid=%b rdata=%h, required 0 / 0123456789abcdef", rvalid[0], rdata[0]);
        end
    endtask

    task automatic test_byte_lanes();
        drive(0, 64'h1D, 8'b0010_0000, 64'h0000_AA00_0000_0000);
        @(negedge clk);
        drive(0, 64'h18, 8'h00, 64'h0);
        @(negedge clk);
        vectors++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 64'h0123_AA67_89AB_CDEF) begin
            miscompares++;
            $display("FAIL byte_lane: rvalid=%b rdata=%h, required 1 / 0123aa6789abcdef", rvalid[0], rdata[0]);
        end
        idle(0);
        @(negedge clk);
    endtask

    task automatic test_pipelined();
        logic exp_v;
        logic [63:0] exp_d;
        for (int j = 1; j <= 3; j++) begin
            drive(1, 64'h1000 + 64'(8 * j), 8'hff, 64'hDEAD_0000_0000_0000 + 64'(j));
            @(negedge clk);
        end
        idle(1);
        repeat (4) @(negedge clk);
        drive(1, 64'h1008, 8'h00, 64'h0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            exp_v = (c >= 3 && c <= 5);
            exp_d = 64'hDEAD_0000_0000_0000 + 64'(c - 2);
            vectors++;
            if (rvalid[1] !== exp_v || (exp_v && rdata[1] !== exp_d)) begin
                miscompares++;
                $display("FAIL pipelined c%0d: rvalid=%b rdata=%h, required %b / %h", c, rvalid[1], rdata[1], exp_v, exp_d);
            end
            if (c < 3) drive(1, 64'h1000 + 64'(8 * (c + 1)), 8'h00, 64'h0);
            else       idle(1);
        end
    endtask

    task automatic test_out_of_range();
        logic [63:0] t_addr [5];
        logic [7:0]  t_wen  [5];
        logic [63:0] t_dat  [5];
        logic        t_vld  [5];
        logic        t_err  [5];
        logic [63:0] t_exp  [5];
        logic        ev, ee;
        t_addr = '{64'h1078, 64'h1078, 64'h1080, 64'h0FF8, 64'h1000};
        t_wen  = '{8'hff, 8'h00, 8'hff, 8'h00, 8'h00};
        t_dat  = '{64'h5A5A_0000_1234_5678, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
        t_vld  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        t_err  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        t_exp  = '{64'h0, 64'h5A5A_0000_1234_5678, 64'h0, 64'h0, 64'h0};
        for (int t = 0; t < 5; t++) begin
            drive(1, t_addr[t], t_wen[t], t_dat[t]);
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                if (c == 1) idle(1);
                ev = (c == 3) && t_vld[t];
                ee = (c == 3) && t_err[t];
                vectors++;
                if (rvalid[1] !== ev || err[1] !== ee || (ev && rdata[1] !== t_exp[t])) begin
                    miscompares++;
                    $display("FAIL range req%0d c%0d: rvalid=%b err=%b rdata=%h, required %b / %b / %h",
                             t, c, rvalid[1], err[1], rdata[1], ev, ee, t_exp[t]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int rdy_at;
        int spurious;
        // Case A: asynchronous clear, then a reset in the middle of the zero-fill.
        rst[0] = 1'b1;
        #1;
        vectors++;
        if (rdata[0] !== 64'h0 || ready[0] !== 1'b0 || rvalid[0] !== 1'b0 || err[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL async_clear dut0: rdata=%h ready=%b, required 0 / 0", rdata[0], ready[0]);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        repeat (7) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        rdy_at = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rdy_at < 0 && ready[0] === 1'b1) rdy_at = k;
        end
        vectors++;
        if (rdy_at != 16) begin
            miscompares++;
            $display("FAIL restart_init: ready after %0d cycles, required 16", rdy_at);
        end
        drive(0, 64'h18, 8'h00, 64'h0);
        @(negedge clk);
        idle(0);
        vectors++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 64'h0) begin
            miscompares++;
            $display("FAIL refill_read: rvalid=%b rdata=%h, required 1 / 0", rvalid[0], rdata[0]);
        end

        // Case B: reset with a read in flight (RD_LAT 2).
        drive(2, 64'h28, 8'hff, 64'hCAFE_F00D_0000_0042);
        @(negedge clk);
        drive(2, 64'h28, 8'h00, 64'h0);
        @(negedge clk);
        idle(2);
        @(negedge clk);
        vectors++;
        if (rvalid[2] !== 1'b1 || rdata[2] !== 64'hCAFE_F00D_0000_0042) begin
            miscompares++;
            $display("FAIL lat2_read: rvalid=%b rdata=%h, required 1 / cafef00d00000042", rvalid[2], rdata[2]);
        end
        drive(2, 64'h28, 8'h00, 64'h0);
        @(negedge clk);
        idle(2);
        rst[2] = 1'b1;
        #1;
        vectors++;
        if (rdata[2] !== 64'h0 || rvalid[2] !== 1'b0 || ready[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL async_clear dut2: rdata=%h rvalid=%b ready=%b, required 0 / 0 / 0", rdata[2], rvalid[2], ready[2]);
        end
        repeat (2) @(negedge clk);
        rst[2] = 1'b0;
        rdy_at = -1;
        spurious = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rvalid[2] !== 1'b0) spurious++;
            if (rdy_at < 0 && ready[2] === 1'b1) rdy_at = k;
        end
        vectors++;
        if (spurious != 0 || rdy_at != 16) begin
            miscompares++;
            $display("FAIL inflight_reset: %0d rvalid cycles, ready after %0d, required 0 / 16", spurious, rdy_at);
        end
    endtask

    initial begin
        test_reset();
        test_init_read();
        test_full_write_read();
        test_byte_lanes();
        test_pipelined();
        test_out_of_range();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder end of the data SRAM interface driven by the execute stage: en/wen/addr/wdata in, rdata back to the memory stage.
- Single-port, doubleword-wide synchronous memory with byte-lane writes, fixed configurable read latency, post-reset zero-fill FSM and out-of-range detection.
- Sits beside the core datapath and replaces the ideal SRAM model in simulation and FPGA builds.

Parameters:
- ADDR_W, 10, doubleword index width; DEPTH = 2**ADDR_W entries of 64 bits.
- BASE_ADDR, 64'h0, byte address of entry 0.
- RD_LAT, 1, read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_sram_en  in  1  request strobe; sampled every rising edge.
- data_sram_wen  in  8  byte write enables (bit i -> wdata[8i+7:8i]); 0 = read.
- data_sram_addr  in  64  byte address; bits [2:0] ignored for indexing.
- data_sram_wdata  in  64  store data, doubleword-aligned lanes.
- data_sram_rdata  out  64  read data.
- data_sram_rvalid  out  1  one-cycle pulse qualifying rdata.
- sram_ready  out  1  1 = requests accepted (init done).
- sram_addr_err  out  1  one-cycle pulse for an out-of-range accepted request.

Behaviour:
- Reset (async, active-high):
  - rdata = 0, rvalid = 0, ready = 0, addr_err = 0.
  - FSM -> INIT, init counter = 0, read pipeline cleared.
- FSM states:
  - INIT: each cycle writes 64'h0 to entry[counter], then counter+1. After entry DEPTH-1 is written -> IDLE. INIT lasts exactly DEPTH cycles after reset release.
  - IDLE: ready = 1. Requests are serviced. No exit except reset.
- ready is registered and rises on the first edge in IDLE. Reset asserted mid-INIT restarts the zero-fill from entry 0.
- Acceptance: a request is accepted at edge T iff en = 1 and ready = 1 at T.
  - Requests while ready = 0 are ignored: no write, no rvalid, no error.
- Range check:
  - off = addr - BASE_ADDR (64-bit unsigned).
  - In range iff addr >= BASE_ADDR and off < 8*DEPTH.
  - Index = off[ADDR_W+2:3].
- Write (wen != 0, accepted, in range):
  - Only enabled byte lanes of entry[index] are updated at edge T.
  - No rvalid is produced.
  - A read accepted at T+1 to the same index sees the new data.
- Read (wen == 0, accepted, in range):
  - Array read at edge T.
  - rvalid pulses and rdata is valid in the cycle after edge T+RD_LAT-1; for RD_LAT = 1, that is the cycle right after the request cycle.
  - Back-to-back reads give back-to-back rvalid pulses in order (fully pipelined, throughput 1 per cycle).
- rdata holds its last value while rvalid = 0.
- Out-of-range:
  - Writes are dropped.
  - Reads return rdata = 0 with rvalid.
  - addr_err pulses aligned with the slot where rvalid would appear (T+RD_LAT timing) for both reads and writes.
- Address arithmetic must not wrap: the addr < BASE_ADDR case is excluded explicitly, not via the subtraction result.
- en = 1 with wen = 0 is always a read; partial wen masks are legal, and 8'hff is a full store.
- No back-pressure. Consumer is always ready.

Test Plan:
- Init:
  - Stimulus: ADDR_W=4, assert reset 3 cycles, release.
  - Response: ready = 0 for exactly 16 cycles, then 1. Reading every entry returns 64'h0 with rvalid one cycle after each request (RD_LAT=1).
- Full write/read:
  - Stimulus: write addr 0x18, wen 8'hff, wdata 64'h0123_4567_89AB_CDEF; then read 0x18 the next cycle.
  - Response: rdata = 64'h0123_4567_89AB_CDEF, rvalid pulses once.
- Byte lanes:
  - Stimulus: after the above, write 0x1D with wen 8'b0010_0000, wdata 64'h0000_AA00_0000_0000; read 0x18.
  - Response: rdata = 64'h0123_AA67_89AB_CDEF.
- Out of range:
  - Stimulus: BASE_ADDR=64'h1000, ADDR_W=4; write 0x1080, then read 0x0FF8.
  - Response: addr_err pulses for each. The read returns rdata = 0 with rvalid. Reading 0x1000 is unchanged (0).
- Pipelined latency:
  - Stimulus: RD_LAT=3, reads to entries 1, 2, 3 on consecutive cycles.
  - Response: three consecutive rvalid pulses starting 3 cycles after the first request, data in request order.
- Reset mid-operation:
  - Case A: assert reset during INIT at counter 7. Response: outputs 0 immediately (asynchronous); after release, ready waits the full DEPTH cycles.
  - Case B: assert reset with a read in flight (RD_LAT=2). Response: no rvalid emerges after release.
